// File: rtl/perfop_result_fifo.sv
// rtl/perfop_result_fifo.sv - FWFT result FIFO with drop flag and running statistics
// Optional macro RESULT_PARITY_EN adds a stored even-parity bit, out_parity and parity_err.
module perfop_result_fifo #(
    parameter int DATA_W = 36,
    parameter int DEPTH  = 8,
    parameter int SUM_W  = 48
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic [DATA_W-1:0]          q_in,
    input  logic                       q_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level,
`ifdef RESULT_PARITY_EN
    output logic                       out_parity,
    output logic                       parity_err,
`endif
    output logic                       overflow,
    output logic [SUM_W-1:0]           sum,
    output logic [15:0]                result_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
`ifdef RESULT_PARITY_EN
    localparam int EW = DATA_W + 1;
`else
    localparam int EW = DATA_W;
`endif

    logic [EW-1:0]     mem_q [DEPTH];
    logic [EW-1:0]     mem_d [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              overflow_q, overflow_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              pop, push;
    logic [EW-1:0]     entry, head;
`ifdef RESULT_PARITY_EN
    logic              out_parity_q, out_parity_d;
    logic              parity_err_q, parity_err_d;
`endif

    always_comb begin
        pop  = out_valid_q && out_ready;
        push = q_valid && ((level_q != LW'(DEPTH)) || pop);
`ifdef RESULT_PARITY_EN
        entry = {^q_in, q_in};
`else
        entry = q_in;
`endif
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        overflow_d  = overflow_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        head        = '0;
`ifdef RESULT_PARITY_EN
        out_parity_d = out_parity_q;
        parity_err_d = parity_err_q;
`endif
        if (clr) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            out_data_d  = '0;
            out_valid_d = 1'b0;
            overflow_d  = 1'b0;
            sum_d       = '0;
            cnt_d       = '0;
`ifdef RESULT_PARITY_EN
            out_parity_d = 1'b0;
            parity_err_d = 1'b0;
`endif
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = entry;
                wr_ptr_d = wr_ptr_q + PW'(1);
                sum_d    = sum_q + {{(SUM_W-DATA_W){1'b0}}, q_in};
                if (cnt_q != 16'hFFFF)
                    cnt_d = cnt_q + 16'd1;
            end
            if (q_valid && !push)
                overflow_d = 1'b1;
            if (pop)
                rd_ptr_d = rd_ptr_q + PW'(1);
            if (push && !pop)
                level_d = level_q + LW'(1);
            else if (pop && !push)
                level_d = level_q - LW'(1);
            // The entry being written this edge is not yet in mem_q, so forward it.
            head = (push && (wr_ptr_q == rd_ptr_d)) ? entry : mem_q[rd_ptr_d];
            out_valid_d = (level_d != '0);
            if (level_d != '0) begin
                out_data_d = head[DATA_W-1:0];
`ifdef RESULT_PARITY_EN
                out_parity_d = head[DATA_W];
`endif
            end
`ifdef RESULT_PARITY_EN
            if (pop && (out_parity_q != ^out_data_q))
                parity_err_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            sum_q       <= '0;
            cnt_q       <= '0;
`ifdef RESULT_PARITY_EN
            out_parity_q <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
`ifdef RESULT_PARITY_EN
            out_parity_q <= out_parity_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign level      = level_q;
    assign overflow   = overflow_q;
    assign sum        = sum_q;
    assign result_cnt = cnt_q;
`ifdef RESULT_PARITY_EN
    assign out_parity = out_parity_q;
    assign parity_err = parity_err_q;
`endif
endmodule

// File: tb/tb_perfop_result_fifo.sv
// tb/tb_perfop_result_fifo.sv - directed and random checks of perfop_result_fifo against a queue model
module tb_perfop_result_fifo;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic [35:0] q_in = '0;
    logic        q_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [35:0] out_data;
    logic        out_valid;
    logic [3:0]  level;
    logic        overflow;
    logic [47:0] sum;
    logic [15:0] result_cnt;
`ifdef RESULT_PARITY_EN
    logic        out_parity;
    logic        parity_err;
`endif

    perfop_result_fifo #(.DATA_W(36), .DEPTH(DEPTH), .SUM_W(48)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .q_in(q_in), .q_valid(q_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .level(level),
`ifdef RESULT_PARITY_EN
        .out_parity(out_parity), .parity_err(parity_err),
`endif
        .overflow(overflow), .sum(sum), .result_cnt(result_cnt)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail = 0;

    logic [35:0] m_q[$];
    logic [47:0] m_sum;
    logic [15:0] m_cnt;
    logic        m_ovf;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        m_sum = '0;
        m_cnt = '0;
        m_ovf = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".level"}, 64'(level), 64'(m_q.size()));
        chk({tag, ".valid"}, 64'(out_valid), 64'(m_q.size() > 0));
        if (m_q.size() > 0)
            chk({tag, ".data"}, 64'(out_data), 64'(m_q[0]));
        chk({tag, ".ovf"}, 64'(overflow), 64'(m_ovf));
        chk({tag, ".sum"}, 64'(sum), 64'(m_sum));
        chk({tag, ".cnt"}, 64'(result_cnt), 64'(m_cnt));
    endtask

    // Called just after a falling edge; applies inputs across one rising edge.
    task automatic cycle(input logic v, input logic [35:0] d, input logic r, input logic c, input string tag);
        logic pop, acc;
        q_valid = v; q_in = d; out_ready = r; clr = c;
        pop = (m_q.size() > 0) && r;
        @(posedge clk);
        if (c) begin
            model_clear();
        end else begin
            acc = v && ((m_q.size() < DEPTH) || pop);
            if (v && !acc) m_ovf = 1'b1;
            if (pop) void'(m_q.pop_front());
            if (acc) begin
                m_q.push_back(d);
                m_sum += {12'd0, d};
                if (m_cnt != 16'hFFFF) m_cnt++;
            end
        end
        @(negedge clk);
        q_valid = 1'b0; clr = 1'b0;
        check_all(tag);
    endtask

    initial begin
        model_clear();
        @(negedge clk);
        chk("rst.data", 64'(out_data), 64'd0);
        check_all("rst");
        rst_n = 1'b1;
        @(negedge clk);

        cycle(1, 36'hA, 0, 0, "p1");
        cycle(1, 36'h3, 0, 0, "p2");
        cycle(1, 36'h8, 0, 0, "p3");
        chk("p3.level", 64'(level), 64'd3);
        chk("p3.data", 64'(out_data), 64'hA);
        chk("p3.sum", 64'(sum), 64'd21);
        for (int i = 0; i < 4; i++) cycle(0, '0, 1, 0, "drain");
        chk("drain.valid", 64'(out_valid), 64'd0);
        chk("drain.sum", 64'(sum), 64'd21);

        cycle(0, '0, 0, 1, "clr0");
        for (int i = 1; i <= 9; i++) cycle(1, 36'(i), 0, 0, "fill9");
        chk("fill9.level", 64'(level), 64'd8);
        chk("fill9.ovf", 64'(overflow), 64'd1);
        chk("fill9.sum", 64'(sum), 64'd36);
        chk("fill9.cnt", 64'(result_cnt), 64'd8);
        for (int i = 0; i < 8; i++) cycle(0, '0, 1, 0, "drain9");

        for (int i = 0; i < 8; i++) cycle(1, 36'(100 + i), 0, 0, "fill8");
        cycle(1, 36'hF_FFFF_FFFF, 1, 0, "fullpp");
        chk("fullpp.level", 64'(level), 64'd8);
        for (int i = 0; i < 7; i++) cycle(0, '0, 1, 0, "drainpp");
        chk("last.data", 64'(out_data), 64'hF_FFFF_FFFF);
        cycle(0, '0, 1, 0, "drainpp_end");

        for (int i = 0; i < 4; i++) cycle(1, 36'(i + 20), 0, 0, "lvl4");
        cycle(1, 36'd5, 1, 1, "clrpush");
        chk("clrpush.level", 64'(level), 64'd0);
        chk("clrpush.cnt", 64'(result_cnt), 64'd0);

        for (int i = 0; i < 400; i++) begin
            logic [35:0] d;
            d = {4'($urandom_range(0, 15)), 32'($urandom)};
            cycle($urandom_range(0, 3) != 0, d, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 63) == 0, "rand");
        end

        for (int i = 0; i < 3; i++) cycle(1, 36'(i + 50), 0, 0, "burst");
        q_valid = 1'b1; q_in = 36'd99;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        chk("arst.data", 64'(out_data), 64'd0);
        check_all("arst");
        q_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1, 36'd7, 0, 0, "post");
        chk("post.valid", 64'(out_valid), 64'd1);
        chk("post.data", 64'(out_data), 64'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
